// File: rtl/v1_pulse_generator.sv
// v1_pulse_generator: synthetic detector pulses (linear rise, exponential tail) on a baseline.
module v1_pulse_generator #(
    parameter int SIZE_ADC_DATA = 14,
    parameter int BASELINE      = 100,
    parameter int RISE_SHIFT    = 2,
    parameter int DECAY_SHIFT   = 4,
    parameter int ACC_W         = SIZE_ADC_DATA + 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     trig_valid,
    input  logic [SIZE_ADC_DATA-1:0] trig_amp,
    output logic                     trig_ready,
    output logic [SIZE_ADC_DATA-1:0] adc_data,
    output logic                     busy,
    output logic [15:0]              pulse_count
);
    localparam int CNT_W = (RISE_SHIFT > 0) ? RISE_SHIFT : 1;
    localparam logic [ACC_W:0] ACC_MAX = (ACC_W+1)'((2 ** ACC_W) - 1);
    localparam logic [ACC_W:0] ADC_MAX = (ACC_W+1)'((2 ** SIZE_ADC_DATA) - 1);

    typedef enum logic [1:0] {IDLE, RISE, DECAY} state_t;

    state_t                   state_q, state_d;
    logic [ACC_W-1:0]         acc_q, acc_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic [SIZE_ADC_DATA-1:0] amp_l_q, amp_l_d;
    logic [SIZE_ADC_DATA-1:0] adc_data_q, adc_data_d;
    logic [15:0]              pulse_count_q, pulse_count_d;
    logic                     busy_q, busy_d;
    logic                     accept;
    logic [ACC_W:0]           rise_sum, out_sum;

    // Held low during reset so no trigger can slip in while the block is cleared.
    assign trig_ready = reset && (state_q == IDLE || state_q == DECAY);
    assign accept     = trig_valid && trig_ready;
    assign rise_sum   = {1'b0, acc_q} + (ACC_W+1)'(amp_l_q >> RISE_SHIFT);
    assign out_sum    = {1'b0, acc_q} + (ACC_W+1)'(BASELINE);

    always_comb begin
        state_d       = state_q;
        acc_d         = acc_q;
        cnt_d         = cnt_q;
        amp_l_d       = amp_l_q;
        pulse_count_d = pulse_count_q;
        if (accept) begin
            amp_l_d       = trig_amp;
            cnt_d         = '0;
            state_d       = RISE;
            pulse_count_d = pulse_count_q + 16'd1;
        end else if (state_q == RISE) begin
            acc_d = (rise_sum > ACC_MAX) ? ACC_MAX[ACC_W-1:0] : rise_sum[ACC_W-1:0];
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'((2 ** RISE_SHIFT) - 1))
                state_d = DECAY;
        end else if (state_q == DECAY) begin
            if (acc_q < ACC_W'(2 ** DECAY_SHIFT)) begin
                acc_d   = '0;
                state_d = IDLE;
            end else begin
                acc_d = acc_q - (acc_q >> DECAY_SHIFT);
            end
        end
        adc_data_d = (out_sum > ADC_MAX) ? ADC_MAX[SIZE_ADC_DATA-1:0] : out_sum[SIZE_ADC_DATA-1:0];
        busy_d     = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= IDLE;
            acc_q         <= '0;
            cnt_q         <= '0;
            amp_l_q       <= '0;
            pulse_count_q <= '0;
            busy_q        <= 1'b0;
            adc_data_q    <= SIZE_ADC_DATA'(BASELINE);
        end else begin
            state_q       <= state_d;
            acc_q         <= acc_d;
            cnt_q         <= cnt_d;
            amp_l_q       <= amp_l_d;
            pulse_count_q <= pulse_count_d;
            busy_q        <= busy_d;
            adc_data_q    <= adc_data_d;
        end
    end

    assign adc_data    = adc_data_q;
    assign busy        = busy_q;
    assign pulse_count = pulse_count_q;
endmodule

// File: tb/tb_v1_pulse_generator.sv
// tb_v1_pulse_generator: scenario and randomized checks of v1_pulse_generator against a pulse model.
module tb_v1_pulse_generator;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        trig_valid = 1'b0;
    logic [13:0] trig_amp = '0;
    logic        trig_ready;
    logic [13:0] adc_data;
    logic        busy;
    logic [15:0] pulse_count;

    v1_pulse_generator dut (
        .clk(clk), .reset(reset), .trig_valid(trig_valid), .trig_amp(trig_amp),
        .trig_ready(trig_ready), .adc_data(adc_data), .busy(busy), .pulse_count(pulse_count)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Pulse model: remaining rise steps plus an "active" flag, integer arithmetic.
    int m_acc, m_rise_left, m_amp, m_count, m_adc;
    bit m_active, m_busy, exp_ready;
    logic obs_ready;
    int seq_single[8] = '{100, 100, 350, 600, 850, 1100, 1038, 980};
    int seq_pile[13]  = '{100, 100, 350, 600, 850, 1100, 1038, 1038, 1163, 1288, 1413, 1538, 1449};

    task automatic m_reset();
        m_acc = 0; m_rise_left = 0; m_amp = 0; m_count = 0; m_adc = 100;
        m_active = 0; m_busy = 0;
    endtask

    task automatic tick(input bit v, input int amp);
        trig_valid = v;
        trig_amp   = amp[13:0];
        #1;
        obs_ready = trig_ready;
        exp_ready = (m_rise_left == 0);
        @(posedge clk);
        m_adc = (100 + m_acc > 16383) ? 16383 : 100 + m_acc;
        if (v && exp_ready) begin
            m_amp = amp; m_rise_left = 4; m_active = 1; m_count = (m_count + 1) % 65536;
        end else if (m_rise_left > 0) begin
            m_acc = m_acc + m_amp / 4;
            if (m_acc > 65535) m_acc = 65535;
            m_rise_left--;
        end else if (m_active) begin
            if (m_acc < 16) begin m_acc = 0; m_active = 0; end
            else m_acc = m_acc - m_acc / 16;
        end
        m_busy = m_active;
        @(negedge clk);
        trig_valid = 1'b0;
    endtask

    task automatic apply_reset();
        trig_valid = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        m_reset();
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_reset();
        trig_valid = 1'b0;
        @(negedge clk);
        #2 reset = 1'b0;
        #1;
        checks++; if (trig_ready !== 1'b0) begin errors++; $display("FAIL reset_ready got=%b exp=0", trig_ready); end
        checks++; if (adc_data !== 14'd100) begin errors++; $display("FAIL reset_adc got=%0d exp=100", adc_data); end
        m_reset();
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 10; i++) tick(0, 0);
        checks++; if (adc_data !== 14'd100) begin errors++; $display("FAIL idle_adc got=%0d exp=100", adc_data); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL idle_busy got=%b exp=0", busy); end
        checks++; if (trig_ready !== 1'b1) begin errors++; $display("FAIL idle_ready got=%b exp=1", trig_ready); end
        checks++; if (pulse_count !== 16'd0) begin errors++; $display("FAIL idle_count got=%0d exp=0", pulse_count); end
    endtask

    task automatic test_single();
        int prev;
        bit done;
        apply_reset();
        for (int i = 0; i < 8; i++) begin
            tick(i == 0, 1000);
            checks++; if (adc_data !== 14'(seq_single[i])) begin errors++; $display("FAIL single_seq i=%0d got=%0d exp=%0d", i, adc_data, seq_single[i]); end
            checks++; if (busy !== m_busy) begin errors++; $display("FAIL single_busy i=%0d got=%b exp=%b", i, busy, m_busy); end
        end
        prev = adc_data;
        done = 0;
        for (int i = 0; i < 200 && !done; i++) begin
            tick(0, 0);
            checks++; if (adc_data !== 14'(m_adc)) begin errors++; $display("FAIL single_tail i=%0d got=%0d exp=%0d", i, adc_data, m_adc); end
            checks++; if (int'(adc_data) > prev) begin errors++; $display("FAIL single_monotonic i=%0d got=%0d exp<=%0d", i, adc_data, prev); end
            prev = adc_data;
            if (!busy) done = 1;
        end
        checks++; if (!done) begin errors++; $display("FAIL single_timeout got=busy exp=idle"); end
        tick(0, 0);
        checks++; if (adc_data !== 14'd100) begin errors++; $display("FAIL single_end_adc got=%0d exp=100", adc_data); end
        checks++; if (trig_ready !== 1'b1) begin errors++; $display("FAIL single_end_ready got=%b exp=1", trig_ready); end
        checks++; if (pulse_count !== 16'd1) begin errors++; $display("FAIL single_count got=%0d exp=1", pulse_count); end
    endtask

    task automatic test_rise_ignore();
        apply_reset();
        for (int i = 0; i < 8; i++) begin
            tick(i == 0 || i == 2, i == 0 ? 1000 : 777);
            if (i == 2) begin
                checks++; if (obs_ready !== 1'b0) begin errors++; $display("FAIL rise_ready got=%b exp=0", obs_ready); end
            end
            checks++; if (adc_data !== 14'(seq_single[i])) begin errors++; $display("FAIL rise_seq i=%0d got=%0d exp=%0d", i, adc_data, seq_single[i]); end
        end
        checks++; if (pulse_count !== 16'd1) begin errors++; $display("FAIL rise_count got=%0d exp=1", pulse_count); end
    endtask

    task automatic test_pileup();
        bit done;
        apply_reset();
        for (int i = 0; i < 13; i++) begin
            tick(i == 0 || i == 6, i == 0 ? 1000 : 500);
            if (i == 6) begin
                checks++; if (obs_ready !== 1'b1) begin errors++; $display("FAIL pile_ready got=%b exp=1", obs_ready); end
            end
            checks++; if (adc_data !== 14'(seq_pile[i])) begin errors++; $display("FAIL pile_seq i=%0d got=%0d exp=%0d", i, adc_data, seq_pile[i]); end
        end
        checks++; if (pulse_count !== 16'd2) begin errors++; $display("FAIL pile_count got=%0d exp=2", pulse_count); end
        done = 0;
        for (int i = 0; i < 200 && !done; i++) begin
            tick(0, 0);
            checks++; if (adc_data !== 14'(m_adc)) begin errors++; $display("FAIL pile_tail i=%0d got=%0d exp=%0d", i, adc_data, m_adc); end
            if (!busy) done = 1;
        end
        checks++; if (!done) begin errors++; $display("FAIL pile_timeout got=busy exp=idle"); end
    endtask

    task automatic test_saturation();
        bit done;
        apply_reset();
        for (int i = 0; i < 23; i++) begin
            tick(i % 5 == 0 && i <= 20, 16383);
            checks++; if (adc_data !== 14'(m_adc)) begin errors++; $display("FAIL sat_rise i=%0d got=%0d exp=%0d", i, adc_data, m_adc); end
        end
        checks++; if (adc_data !== 14'd16383) begin errors++; $display("FAIL sat_clamp got=%0d exp=16383", adc_data); end
        checks++; if (pulse_count !== 16'd5) begin errors++; $display("FAIL sat_count got=%0d exp=5", pulse_count); end
        done = 0;
        for (int i = 0; i < 400 && !done; i++) begin
            tick(0, 0);
            checks++; if (adc_data !== 14'(m_adc)) begin errors++; $display("FAIL sat_tail i=%0d got=%0d exp=%0d", i, adc_data, m_adc); end
            if (!busy) done = 1;
        end
        checks++; if (!done) begin errors++; $display("FAIL sat_timeout got=busy exp=idle"); end
    endtask

    task automatic test_zero_amp();
        apply_reset();
        for (int i = 0; i < 7; i++) begin
            tick(i == 0, 0);
            checks++; if (busy !== (i < 5)) begin errors++; $display("FAIL zero_busy i=%0d got=%b exp=%b", i, busy, i < 5); end
            checks++; if (adc_data !== 14'd100) begin errors++; $display("FAIL zero_adc i=%0d got=%0d exp=100", i, adc_data); end
        end
        checks++; if (pulse_count !== 16'd1) begin errors++; $display("FAIL zero_count got=%0d exp=1", pulse_count); end
    endtask

    task automatic test_async_reset();
        apply_reset();
        tick(1, 1000);
        for (int i = 0; i < 40 && (m_rise_left > 0 || m_acc > 520); i++) tick(0, 0);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL areset_pre_busy got=%b exp=1", busy); end
        #2 reset = 1'b0;
        #1;
        checks++; if (adc_data !== 14'd100) begin errors++; $display("FAIL areset_adc got=%0d exp=100", adc_data); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL areset_busy got=%b exp=0", busy); end
        checks++; if (pulse_count !== 16'd0) begin errors++; $display("FAIL areset_count got=%0d exp=0", pulse_count); end
        m_reset();
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick(0, 0);
            checks++; if (adc_data !== 14'd100) begin errors++; $display("FAIL areset_residual i=%0d got=%0d exp=100", i, adc_data); end
        end
        for (int i = 0; i < 8; i++) begin
            tick(i == 0, 1000);
            checks++; if (adc_data !== 14'(seq_single[i])) begin errors++; $display("FAIL areset_replay i=%0d got=%0d exp=%0d", i, adc_data, seq_single[i]); end
        end
    endtask

    task automatic test_random();
        apply_reset();
        for (int i = 0; i < 800; i++) begin
            tick($urandom_range(0, 5) == 0, ($urandom_range(0, 3) == 0) ? 16383 - $urandom_range(0, 200) : $urandom_range(0, 16383));
            checks++; if (obs_ready !== exp_ready) begin errors++; $display("FAIL rand_ready i=%0d got=%b exp=%b", i, obs_ready, exp_ready); end
            checks++; if (adc_data !== 14'(m_adc)) begin errors++; $display("FAIL rand_adc i=%0d got=%0d exp=%0d", i, adc_data, m_adc); end
            checks++; if (busy !== m_busy) begin errors++; $display("FAIL rand_busy i=%0d got=%b exp=%b", i, busy, m_busy); end
            checks++; if (pulse_count !== 16'(m_count)) begin errors++; $display("FAIL rand_count i=%0d got=%0d exp=%0d", i, pulse_count, m_count); end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_rise_ignore();
        test_pileup();
        test_saturation();
        test_zero_amp();
        test_async_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
